// File: rtl/pipeline_2_operand.sv
// pipeline_2_operand: operand-fetch stage between read-reg and execute.
// Holds the 8x16 register file, reads three sources per cycle, detects
// load-use (and, without bypass, writeback) hazards, and either advances
// the instruction or inserts a bubble on each update.
//
// Stage-advance semantics: "update" is a global advance strobe. When
// update=1 the output register takes either the new instruction
// (stall=0) or an all-zero bubble (stall=1). When update=0 the whole
// output register and the stall counter hold. stall is combinational
// and goes back to the upstream stages in the same cycle.
//
// Optional build macro: PIPELINE_2_BYPASS_EN -- when defined, a source
// read that matches the register being written this cycle returns the
// writeback data directly; when undefined such a read stalls instead.
module pipeline_2_operand (
   input  logic        clk,
   input  logic        rst,
   input  logic        update,
   input  logic [21:0] control_in,
   input  logic [2:0]  num_Rm_in,
   input  logic [2:0]  num_Rn_in,
   input  logic [2:0]  num_Rram_in,
   input  logic [15:0] imm_in,
   input  logic        wb_en,
   input  logic [2:0]  wb_num,
   input  logic [15:0] wb_data,
   input  logic        ex_load,
   input  logic [2:0]  ex_dest,
   output logic [21:0] control_out,
   output logic [15:0] val_A,
   output logic [15:0] val_B,
   output logic [15:0] val_ram,
   output logic [15:0] imm_out,
   output logic        stall,
   output logic [15:0] stall_count
);

   logic [15:0] regs_q [0:7];
   logic [15:0] regs_d [0:7];

   logic [21:0] control_q, control_d;
   logic [15:0] val_a_q, val_a_d;
   logic [15:0] val_b_q, val_b_d;
   logic [15:0] val_ram_q, val_ram_d;
   logic [15:0] imm_q, imm_d;
   logic [15:0] stall_count_q, stall_count_d;

   logic [15:0] rd_rm, rd_rn, rd_rram;
   logic        load_hit;
   logic        wb_hit;

   // Combinational source reads, with optional same-cycle writeback bypass.
   always_comb begin
      rd_rm   = regs_q[num_Rm_in];
      rd_rn   = regs_q[num_Rn_in];
      rd_rram = regs_q[num_Rram_in];
`ifdef PIPELINE_2_BYPASS_EN
      if (wb_en && (wb_num == num_Rm_in))   rd_rm   = wb_data;
      if (wb_en && (wb_num == num_Rn_in))   rd_rn   = wb_data;
      if (wb_en && (wb_num == num_Rram_in)) rd_rram = wb_data;
`endif
   end

   // Hazard detection: load-use always; writeback collision only when
   // there is no bypass path to forward the data.
   always_comb begin
      load_hit = ex_load &&
                 ((control_in[1] && (ex_dest == num_Rm_in))   ||
                  (control_in[2] && (ex_dest == num_Rn_in))   ||
                  (control_in[3] && (ex_dest == num_Rram_in)));
`ifdef PIPELINE_2_BYPASS_EN
      wb_hit   = 1'b0;
`else
      wb_hit   = wb_en &&
                 ((control_in[1] && (wb_num == num_Rm_in))   ||
                  (control_in[2] && (wb_num == num_Rn_in))   ||
                  (control_in[3] && (wb_num == num_Rram_in)));
`endif
      // Invalid instructions never stall.
      stall    = control_in[0] && (load_hit || wb_hit);
   end

   // Writeback path: independent of update and stall.
   always_comb begin
      regs_d = regs_q;
      if (wb_en) regs_d[wb_num] = wb_data;
   end

   // Next state of the stage register: advance, bubble, or hold.
   always_comb begin
      control_d     = control_q;
      val_a_d       = val_a_q;
      val_b_d       = val_b_q;
      val_ram_d     = val_ram_q;
      imm_d         = imm_q;
      stall_count_d = stall_count_q;
      if (update) begin
         if (stall) begin
            control_d = '0;
            val_a_d   = '0;
            val_b_d   = '0;
            val_ram_d = '0;
            imm_d     = '0;
            if (stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
         end else begin
            control_d = control_in;
            val_a_d   = rd_rm;
            val_b_d   = rd_rn;
            val_ram_d = rd_rram;
            imm_d     = imm_in;
         end
      end
   end

   // State registers; reset wins over both update and writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
         control_q     <= '0;
         val_a_q       <= '0;
         val_b_q       <= '0;
         val_ram_q     <= '0;
         imm_q         <= '0;
         stall_count_q <= '0;
      end else begin
         for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
         control_q     <= control_d;
         val_a_q       <= val_a_d;
         val_b_q       <= val_b_d;
         val_ram_q     <= val_ram_d;
         imm_q         <= imm_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign control_out = control_q;
   assign val_A       = val_a_q;
   assign val_B       = val_b_q;
   assign val_ram     = val_ram_q;
   assign imm_out     = imm_q;
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_2_operand.sv
// Bench for pipeline_2_operand: directed scenarios, randomized traffic and
// a stall-counter saturation run, checked by a queue-based scoreboard
// against a behavioural model of the stage.
module tb_pipeline_2_operand;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        update = 1'b0;
  logic [21:0] control_in = '0;
  logic [2:0]  num_Rm_in = '0, num_Rn_in = '0, num_Rram_in = '0;
  logic [15:0] imm_in = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_num = '0;
  logic [15:0] wb_data = '0;
  logic        ex_load = 1'b0;
  logic [2:0]  ex_dest = '0;
  logic [21:0] control_out;
  logic [15:0] val_A, val_B, val_ram, imm_out, stall_count;
  logic        stall;

  pipeline_2_operand dut (
    .clk(clk), .rst(rst), .update(update), .control_in(control_in),
    .num_Rm_in(num_Rm_in), .num_Rn_in(num_Rn_in), .num_Rram_in(num_Rram_in),
    .imm_in(imm_in), .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
    .ex_load(ex_load), .ex_dest(ex_dest), .control_out(control_out),
    .val_A(val_A), .val_B(val_B), .val_ram(val_ram), .imm_out(imm_out),
    .stall(stall), .stall_count(stall_count)
  );

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  // Observable state: register file contents plus the stage outputs.
  logic [15:0] m_rf [8];
  logic [21:0] m_ctrl;
  logic [15:0] m_a, m_b, m_ram, m_imm;
  int          m_cnt;

  // expected {control_out, val_A, val_B, val_ram, imm_out, stall_count}
  logic [101:0] exp_q[$];

  function automatic logic [15:0] m_read(input logic [2:0] n, input logic we,
                                         input logic [2:0] wn, input logic [15:0] wd);
    logic [15:0] v;
    v = m_rf[n];
`ifdef PIPELINE_2_BYPASS_EN
    if (we && wn == n) v = wd;
`endif
    return v;
  endfunction

  function automatic logic m_stall(input logic [21:0] ci, input logic [2:0] rm,
                                   input logic [2:0] rn, input logic [2:0] rr,
                                   input logic we, input logic [2:0] wn,
                                   input logic el, input logic [2:0] ed);
    logic [2:0] src [3];
    logic hz;
    src[0] = rm; src[1] = rn; src[2] = rr;
    hz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (ci[k+1]) begin
        if (el && ed == src[k]) hz = 1'b1;
`ifndef PIPELINE_2_BYPASS_EN
        if (we && wn == src[k]) hz = 1'b1;
`endif
      end
    end
    return ci[0] && hz;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic upd, input logic [21:0] ci,
                       input logic [2:0] rm, input logic [2:0] rn, input logic [2:0] rr,
                       input logic [15:0] imm, input logic we, input logic [2:0] wn,
                       input logic [15:0] wd, input logic el, input logic [2:0] ed);
    logic exp_stall;
    logic [15:0] ra, rb, rc;
    @(negedge clk);
    rst = r; update = upd; control_in = ci; num_Rm_in = rm; num_Rn_in = rn;
    num_Rram_in = rr; imm_in = imm; wb_en = we; wb_num = wn; wb_data = wd;
    ex_load = el; ex_dest = ed;
    #1;
    exp_stall = m_stall(ci, rm, rn, rr, we, wn, el, ed);
    total++;
    if (stall !== exp_stall) begin
      bad++;
      $display("FAIL stall: got %b expected %b (ci=%h rm=%0d rn=%0d rr=%0d we=%b wn=%0d el=%b ed=%0d)",
               stall, exp_stall, ci, rm, rn, rr, we, wn, el, ed);
    end
    ra = m_read(rm, we, wn, wd);
    rb = m_read(rn, we, wn, wd);
    rc = m_read(rr, we, wn, wd);
    if (r) begin
      for (int k = 0; k < 8; k++) m_rf[k] = '0;
      m_ctrl = '0; m_a = '0; m_b = '0; m_ram = '0; m_imm = '0; m_cnt = 0;
    end else begin
      if (upd) begin
        if (exp_stall) begin
          m_ctrl = '0; m_a = '0; m_b = '0; m_ram = '0; m_imm = '0;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
          m_ctrl = ci; m_a = ra; m_b = rb; m_ram = rc; m_imm = imm;
        end
      end
      if (we) m_rf[wn] = wd;
    end
    exp_q.push_back({m_ctrl, m_a, m_b, m_ram, m_imm, 16'(m_cnt)});
  endtask

  task automatic idle_cycle(input logic upd);
    drive(1'b0, upd, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [101:0] act, exp_v;
    #2;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act = {control_out, val_A, val_B, val_ram, imm_out, stall_count};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL outputs: got ctrl=%h A=%h B=%h ram=%h imm=%h cnt=%h expected ctrl=%h A=%h B=%h ram=%h imm=%h cnt=%h",
                 act[101:80], act[79:64], act[63:48], act[47:32], act[31:16], act[15:0],
                 exp_v[101:80], exp_v[79:64], exp_v[63:48], exp_v[47:32], exp_v[31:16], exp_v[15:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rnd;
    logic [21:0] ci;
    for (int k = 0; k < 8; k++) m_rf[k] = '0;
    m_ctrl = '0; m_a = '0; m_b = '0; m_ram = '0; m_imm = '0; m_cnt = 0;

    // Reset with a coincident write to R2 that must be dropped; then read R2.
    drive(1'b1, 1'b1, 22'h3, 3'd2, 3'd0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h1234, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 22'h3, 3'd2, 3'd0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);

    // Write R3, then read it through Rm.
    drive(1'b0, 1'b0, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 22'h3, 3'd3, 3'd0, 3'd0, 16'h0055, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);

    // Load-use hazard on Rn.
    drive(1'b0, 1'b1, 22'h5, 3'd0, 3'd5, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);

    // Same-cycle writeback collision on Rm, then retry.
    drive(1'b0, 1'b1, 22'h3, 3'd4, 3'd0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h00AA, 1'b0, 3'd0);
    drive(1'b0, 1'b1, 22'h3, 3'd4, 3'd0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);

    // Hold with a stalling instruction present: nothing may change.
    repeat (3) drive(1'b0, 1'b0, 22'h5, 3'd0, 3'd5, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);

    // Invalid instruction with a matching load never stalls.
    drive(1'b0, 1'b1, 22'hE, 3'd5, 3'd5, 3'd5, 16'h1111, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);

    // Randomized traffic; small register space makes hazards frequent.
    for (int n = 0; n < 1500; n++) begin
      rnd = $urandom;
      ci = rnd[21:0];
      ci[0] = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), ci,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom), ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
            16'($urandom), ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
    end

    // Stall counter saturation: 65534 stalls to reach FFFE, then 3 more.
    drive(1'b1, 1'b0, 22'h0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    for (int n = 0; n < 65534 + 3; n++)
      drive(1'b0, 1'b1, 22'h3, 3'd6, 3'd0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6);
    idle_cycle(1'b0);

    // Drain the scoreboard, then a direct check of the saturated count.
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    total++;
    if (stall_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL saturate: got stall_count=%h expected ffff", stall_count);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
